// File: rtl/cdb_broadcast_pkg.sv
// ---------------------------------------------------------------------------
// cdb_broadcast_pkg
//   Shared machine-wide constants and types for the result broadcast path:
//   superscalar width, functional-unit count and indices, physical register
//   tag width, the CDB entry record and a small index-wrapping helper.
// ---------------------------------------------------------------------------
package cdb_broadcast_pkg;

    localparam int SS_SIZE      = 2;    // CDB broadcast slots per cycle
    localparam int NUM_FU_TOTAL = 5;    // ALU0, ALU1, LD, MULT, BR
    localparam int NUM_PHYS_REG = 128;
    localparam int PHYS_TAG_W   = $clog2(NUM_PHYS_REG);
    localparam int XLEN         = 32;

    localparam int FU_ALU0_IDX  = 0;
    localparam int FU_ALU1_IDX  = 1;
    localparam int FU_LD_IDX    = 2;
    localparam int FU_MULT_IDX  = 3;
    localparam int FU_BR_IDX    = 4;

    // Physical register as seen on the CDB: {ready, tag}
    typedef logic [PHYS_TAG_W:0] phys_reg_t;

    typedef struct packed {
        logic [PHYS_TAG_W-1:0] tag;
        logic [XLEN-1:0]       value;
    } cdb_entry_t;

    // (idx + 1) mod modulus, for idx already in [0, modulus)
    function automatic int wrap_inc(input int idx, input int modulus);
        return (idx + 1 >= modulus) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_broadcast_if.sv
// ---------------------------------------------------------------------------
// cdb_broadcast_if
//   Bundle between the functional units / reservation station side and the
//   CDB broadcaster.
//   master : drives fu_done/fu_tag/fu_value and branch_not_taken, observes
//            the CDB slots, issue_stall and overflow_err.
//   slave  : the broadcaster (cdb_broadcast).
// ---------------------------------------------------------------------------
interface cdb_broadcast_if
    import cdb_broadcast_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_TOTAL,
    parameter int CDB_W  = SS_SIZE,
    parameter int TAG_W  = PHYS_TAG_W,
    parameter int DATA_W = XLEN
);
    logic                               branch_not_taken;
    logic [NUM_FU-1:0]                  fu_done;
    logic [NUM_FU-1:0][TAG_W-1:0]       fu_tag;
    logic [NUM_FU-1:0][DATA_W-1:0]      fu_value;
    logic [CDB_W-1:0][TAG_W:0]          CDB_out;     // {ready, tag} per slot
    logic [CDB_W-1:0][DATA_W-1:0]       CDB_value;
    logic [CDB_W-1:0]                   CAM_en;
    logic [NUM_FU-1:0]                  issue_stall;
    logic                               overflow_err;

    modport master (
        output branch_not_taken, fu_done, fu_tag, fu_value,
        input  CDB_out, CDB_value, CAM_en, issue_stall, overflow_err
    );

    modport slave (
        input  branch_not_taken, fu_done, fu_tag, fu_value,
        output CDB_out, CDB_value, CAM_en, issue_stall, overflow_err
    );
endinterface

// File: rtl/cdb_broadcast_fifo.sv
// ---------------------------------------------------------------------------
// cdb_fifo
//   Per-FU result FIFO.  Push and pop in the same cycle are accepted at any
//   occupancy (including full); a push into a full FIFO without a pop is
//   ignored.  flush_i empties the FIFO at the edge and overrides push/pop.
//   Ports: clk_i, rst_ni (async active-low), push_i, pop_i, flush_i,
//          din_i (entry to enqueue), head_o (oldest entry), empty_o, count_o.
// ---------------------------------------------------------------------------
module cdb_fifo
    import cdb_broadcast_pkg::*;
#(
    parameter int  BUF_DEPTH = 2,
    parameter type ENTRY_T   = cdb_entry_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  ENTRY_T                     din_i,
    output ENTRY_T                     head_o,
    output logic                       empty_o,
    output logic [$clog2(BUF_DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    ENTRY_T           mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    // A full FIFO can still take a push when its head leaves in the same cycle
    assign do_push = push_i & ((count_q != FULL_CNT) | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is only consumed when count is non-zero
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/cdb_broadcast.sv
// ---------------------------------------------------------------------------
// cdb_broadcast
//   Collects functional-unit completions into one small FIFO per FU and
//   broadcasts up to CDB_W {tag,value} results per cycle on the CDB, picking
//   FUs in rotating priority starting at rr_ptr.  Drives issue_stall so the
//   RS stops issuing to an FU whose result buffer is about to fill, and a
//   sticky overflow_err if a result ever arrives at a full buffer.
//   Ports: clock, reset (async, active-low), bus (cdb_broadcast_if.slave).
//   Optional feature: define CDB_BYPASS_EN to let a result arriving at an
//   empty FIFO compete for a slot in the same cycle.
// ---------------------------------------------------------------------------
module cdb_broadcast
    import cdb_broadcast_pkg::*;
#(
    parameter int NUM_FU    = NUM_FU_TOTAL,
    parameter int CDB_W     = SS_SIZE,
    parameter int BUF_DEPTH = 2,
    parameter int TAG_W     = $clog2(NUM_PHYS_REG),
    parameter int DATA_W    = 32
) (
    input  logic           clock,
    input  logic           reset,
    cdb_broadcast_if.slave bus
);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] NEAR_CNT = CNT_W'(BUF_DEPTH - 1);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } entry_t;

    entry_t            incoming [NUM_FU];
    entry_t            head     [NUM_FU];
    entry_t            cand     [NUM_FU];
    logic [CNT_W-1:0]  count    [NUM_FU];
    logic [NUM_FU-1:0] empty, cand_vld, grant, pop, push, bypass, stall;
    entry_t            slot_ent [CDB_W];
    logic [CDB_W-1:0]  slot_vld;
    logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              overflow_err_q, overflow_err_d;
    logic              flush;

    assign flush = bus.branch_not_taken;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign incoming[i] = {bus.fu_tag[i], bus.fu_value[i]};

        cdb_fifo #(
            .BUF_DEPTH (BUF_DEPTH),
            .ENTRY_T   (entry_t)
        ) u_fifo (
            .clk_i   (clock),
            .rst_ni  (reset),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .flush_i (flush),
            .din_i   (incoming[i]),
            .head_o  (head[i]),
            .empty_o (empty[i]),
            .count_o (count[i])
        );
    end

    // Arbitration candidates: the FIFO head, or with bypass the incoming
    // result of an FU whose FIFO is empty
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            cand_vld[i] = ~empty[i];
            cand[i]     = head[i];
`ifdef CDB_BYPASS_EN
            if (empty[i] && bus.fu_done[i]) begin
                cand_vld[i] = 1'b1;
                cand[i]     = incoming[i];
            end
`endif
        end
    end

    // Rotating-priority selector: first CDB_W candidates in scan order from
    // rr_ptr get slots 0..CDB_W-1; the pointer moves past the last winner
    always_comb begin
        int n;
        int idx;
        grant    = '0;
        slot_vld = '0;
        rr_ptr_d = rr_ptr_q;
        for (int s = 0; s < CDB_W; s++) slot_ent[s] = '0;
        n = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (!flush && cand_vld[idx] && n < CDB_W) begin
                grant[idx]    = 1'b1;
                slot_vld[n]   = 1'b1;
                slot_ent[n]   = cand[idx];
                rr_ptr_d      = RR_W'(wrap_inc(idx, NUM_FU));
                n             = n + 1;
            end
        end
    end

    always_comb begin
        overflow_err_d = overflow_err_q;
        for (int i = 0; i < NUM_FU; i++) begin
            // A grant to an empty FIFO can only be a bypassed result
            pop[i]    = grant[i] & ~empty[i];
            bypass[i] = grant[i] & empty[i];
            push[i]   = bus.fu_done[i] & ~flush & ~bypass[i]
                      & ((count[i] != FULL_CNT) | pop[i]);
            stall[i]  = (count[i] == FULL_CNT)
                      | ((count[i] == NEAR_CNT) & bus.fu_done[i] & ~pop[i]);
            if (bus.fu_done[i] && count[i] == FULL_CNT && !pop[i])
                overflow_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q       <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    // Unused slots carry all-zero entries, so the ready bit is just the valid
    for (genvar s = 0; s < CDB_W; s++) begin : g_slot
        assign bus.CAM_en[s]    = slot_vld[s];
        assign bus.CDB_out[s]   = {slot_vld[s], slot_ent[s].tag};
        assign bus.CDB_value[s] = slot_ent[s].value;
    end

    assign bus.issue_stall  = stall;
    assign bus.overflow_err = overflow_err_q;

endmodule
